// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Byte-stream handshake and instruction-memory write port bundle
//            for the instruction memory loader.
// Revision : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic [7:0]            byte_in;
  logic                  byte_valid_in;
  logic                  byte_ready_out;
  logic                  imem_write_en_out;
  logic [ADDR_WIDTH-1:0] imem_addr_out;
  logic [31:0]           imem_data_out;

  // Host / memory side: drives the byte stream, observes the write port
  modport master (
    output byte_in,
    output byte_valid_in,
    input  byte_ready_out,
    input  imem_write_en_out,
    input  imem_addr_out,
    input  imem_data_out
  );

  // Loader side
  modport slave (
    input  byte_in,
    input  byte_valid_in,
    output byte_ready_out,
    output imem_write_en_out,
    output imem_addr_out,
    output imem_data_out
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Fills instruction memory from a byte stream carrying a 16-bit
//            little-endian word count, little-endian payload words and an
//            XOR checksum, then releases the core from hold.
// Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               start_in,
  imem_loader_if.slave       bus,
  output logic               core_hold_out,
  output logic               done_out,
  output logic               error_out,
  output logic [15:0]        words_loaded_out
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LEN_LO = 3'd1;
  localparam logic [2:0] c_LEN_HI = 3'd2;
  localparam logic [2:0] c_DATA   = 3'd3;
  localparam logic [2:0] c_CHECK  = 3'd4;
  localparam logic [2:0] c_DONE   = 3'd5;
  localparam logic [2:0] c_ERROR  = 3'd6;

  // Largest legal word count; one bit wider than the header so 2^16 fits
  localparam logic [16:0] c_CAPACITY = 17'd1 << ADDR_WIDTH;

  logic [2:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  hold_q, hold_d;

  logic [7:0]            len_lo_q;
  logic [15:0]           length_q;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           asm_q;
  logic [7:0]            csum_q;
  logic [ADDR_WIDTH-1:0] word_idx_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [15:0]           words_q;

  logic                  xfer_w;
  logic                  start_w;
  logic [16:0]           length_w;
  logic                  last_word_w;

  assign xfer_w      = bus.byte_valid_in && ready_q;
  assign start_w     = start_in &&
                       ((state_q == c_IDLE) || (state_q == c_DONE) || (state_q == c_ERROR));
  assign length_w    = {1'b0, bus.byte_in, len_lo_q};
  assign last_word_w = ((words_q + 16'd1) == length_q);

  // State register plus the status flags decoded from the next state,
  // so every flag changes on the same edge as the state it reflects
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= c_IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; states only advance on an accepted byte or start
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE, c_DONE, c_ERROR: begin
        if (start_in) state_d = c_LEN_LO;
      end
      c_LEN_LO: begin
        if (xfer_w) state_d = c_LEN_HI;
      end
      c_LEN_HI: begin
        if (xfer_w) begin
          if (length_w > c_CAPACITY)  state_d = c_ERROR;
          else if (length_w == 17'd0) state_d = c_CHECK;
          else                        state_d = c_DATA;
        end
      end
      c_DATA: begin
        if (xfer_w && (byte_cnt_q == 2'd3) && last_word_w) state_d = c_CHECK;
      end
      c_CHECK: begin
        if (xfer_w) state_d = (bus.byte_in == csum_q) ? c_DONE : c_ERROR;
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    ready_d = (state_d == c_LEN_LO) || (state_d == c_LEN_HI) ||
              (state_d == c_DATA)   || (state_d == c_CHECK);
    done_d  = (state_d == c_DONE);
    error_d = (state_d == c_ERROR);
    hold_d  = (state_d != c_DONE);
  end

  // Datapath: header capture, word assembly, checksum and memory write
  always_ff @(posedge clk_in) begin
    if (reset) begin
      len_lo_q   <= '0;
      length_q   <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      words_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (start_w) begin
        words_q    <= '0;
        csum_q     <= '0;
        byte_cnt_q <= '0;
        word_idx_q <= '0;
      end
      if (xfer_w) begin
        case (state_q)
          c_LEN_LO: len_lo_q <= bus.byte_in;
          c_LEN_HI: length_q <= length_w[15:0];
          c_DATA: begin
            csum_q     <= csum_q ^ bus.byte_in;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              // asm_q already holds bytes 2..0 in little-endian order
              wr_en_q    <= 1'b1;
              addr_q     <= word_idx_q;
              data_q     <= {bus.byte_in, asm_q};
              word_idx_q <= word_idx_q + 1'b1;
              words_q    <= words_q + 16'd1;
            end else begin
              asm_q <= {bus.byte_in, asm_q[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_ready_out    = ready_q;
  assign bus.imem_write_en_out = wr_en_q;
  assign bus.imem_addr_out     = addr_q;
  assign bus.imem_data_out     = data_q;
  assign core_hold_out         = hold_q;
  assign done_out              = done_q;
  assign error_out             = error_q;
  assign words_loaded_out      = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Scoreboard bench for imem_loader with a stream-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;
  localparam int AW  = 10;
  localparam int CAP = 1 << AW;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        start_in = 1'b0;
  logic        core_hold_out, done_out, error_out;
  logic [15:0] words_loaded_out;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .start_in         (start_in),
    .bus              (bus),
    .core_hold_out    (core_hold_out),
    .done_out         (done_out),
    .error_out        (error_out),
    .words_loaded_out (words_loaded_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic          prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops one expected (addr,data) pair
  always @(negedge clk_in) begin : mon
    logic [AW-1:0] a;
    logic [31:0]   d;
    if (!reset) begin
      if (bus.imem_write_en_out) begin
        check("strobe_single_cycle", {31'b0, prev_we}, 32'd0);
        check("write_expected", {31'b0, exp_addr.size() != 0}, 32'd1);
        if (exp_addr.size() != 0) begin
          a = exp_addr.pop_front();
          d = exp_data.pop_front();
          check("wr_addr", {{(32-AW){1'b0}}, bus.imem_addr_out}, {{(32-AW){1'b0}}, a});
          check("wr_data", bus.imem_data_out, d);
        end
      end
      check("done_error_exclusive", {31'b0, done_out & error_out}, 32'd0);
    end
    prev_we <= bus.imem_write_en_out;
  end

  // Stream-level model: pushes expected writes, returns result and length
  task automatic model_load(input logic [7:0] s[$], output bit exp_done,
                            output int exp_words, output int n_bytes);
    int len;
    logic [7:0] csum;
    len = int'(s[0]) + (int'(s[1]) << 8);
    if (len > CAP) begin
      exp_done = 0; exp_words = 0; n_bytes = 2;
      return;
    end
    csum = 8'h00;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(AW'(i % CAP));
      exp_data.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
      for (int k = 0; k < 4; k++) csum = csum ^ s[2+4*i+k];
    end
    exp_words = len;
    n_bytes   = 3 + 4 * len;
    exp_done  = (s[n_bytes-1] == csum);
  endtask

  task automatic make_stream(input int len, input bit good, output logic [7:0] s[$]);
    logic [7:0] csum, b;
    s = {};
    s.push_back(len[7:0]);
    s.push_back(len[15:8]);
    csum = 8'h00;
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom);
      csum = csum ^ b;
      s.push_back(b);
    end
    s.push_back(good ? csum : (csum ^ 8'(1 + $urandom_range(254, 0))));
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap, budget;
    gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    budget = 0;
    bus.byte_valid_in = 1'b0;
    repeat (gap) begin
      bus.byte_in = 8'($urandom);
      @(negedge clk_in);
    end
    bus.byte_in = b;
    bus.byte_valid_in = 1'b1;
    while (!bus.byte_ready_out && budget < 50) begin
      @(negedge clk_in);
      budget++;
    end
    check("ready_within_budget", {31'b0, budget < 50}, 32'd1);
    @(negedge clk_in);
    bus.byte_valid_in = 1'b0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check("start_clears_done", {31'b0, done_out}, 32'd0);
    check("start_sets_hold", {31'b0, core_hold_out}, 32'd1);
    check("start_ready", {31'b0, bus.byte_ready_out}, 32'd1);
  endtask

  task automatic run_load(input logic [7:0] s[$], input int gap_max);
    bit ed;
    int ew, n;
    model_load(s, ed, ew, n);
    pulse_start();
    for (int i = 0; i < n; i++) send_byte(s[i], gap_max);
    @(negedge clk_in);
    check("done", {31'b0, done_out}, {31'b0, ed});
    check("error", {31'b0, error_out}, {31'b0, !ed});
    check("core_hold", {31'b0, core_hold_out}, {31'b0, !ed});
    check("ready_idle", {31'b0, bus.byte_ready_out}, 32'd0);
    check("words_loaded", {16'b0, words_loaded_out}, ew);
    check("all_writes_seen", exp_addr.size(), 32'd0);
    exp_addr = {};
    exp_data = {};
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nominal[$], bad[$], zero[$], over[$], s[$];
    nominal = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    bad     = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
    zero    = '{8'h00, 8'h00, 8'h00};
    over    = '{8'h01, 8'h04};
    bus.byte_in = 8'h00;
    bus.byte_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_ready", {31'b0, bus.byte_ready_out}, 32'd0);
    check("rst_we", {31'b0, bus.imem_write_en_out}, 32'd0);
    check("rst_addr", {{(32-AW){1'b0}}, bus.imem_addr_out}, 32'd0);
    check("rst_data", bus.imem_data_out, 32'd0);
    check("rst_hold", {31'b0, core_hold_out}, 32'd1);
    check("rst_done", {31'b0, done_out}, 32'd0);
    check("rst_error", {31'b0, error_out}, 32'd0);
    check("rst_words", {16'b0, words_loaded_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk_in);

    run_load(nominal, 0);
    run_load(zero, 0);
    run_load(bad, 0);
    run_load(over, 0);
    run_load(nominal, 4);

    // Reset after six payload bytes, then a full reload
    exp_addr.push_back('0);
    exp_data.push_back(32'h0000_0013);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(nominal[i], 2);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check("midrst_ready", {31'b0, bus.byte_ready_out}, 32'd0);
    check("midrst_words", {16'b0, words_loaded_out}, 32'd0);
    check("midrst_writes", exp_addr.size(), 32'd0);
    run_load(nominal, 0);

    // Reset coinciding with the fourth payload byte drops that write
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(nominal[i], 0);
    bus.byte_in = nominal[5];
    bus.byte_valid_in = 1'b1;
    reset = 1'b1;
    @(negedge clk_in);
    bus.byte_valid_in = 1'b0;
    reset = 1'b0;
    check("rst_drop_we", {31'b0, bus.imem_write_en_out}, 32'd0);
    @(negedge clk_in);
    check("rst_drop_we_after", {31'b0, bus.imem_write_en_out}, 32'd0);

    // Reset and start together: reset wins
    reset = 1'b1;
    start_in = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    start_in = 1'b0;
    @(negedge clk_in);
    check("rst_beats_start", {31'b0, bus.byte_ready_out}, 32'd0);
    check("rst_beats_start_hold", {31'b0, core_hold_out}, 32'd1);

    run_load(nominal, 0);
    run_load(nominal, 1);

    // Full capacity load at full rate, then one word past capacity
    make_stream(CAP, 1'b1, s);
    run_load(s, 0);
    make_stream(CAP + 1, 1'b1, s);
    s = s[0:1];
    run_load(s, 0);
    s = '{8'hFF, 8'hFF};
    run_load(s, 0);

    for (int t = 0; t < 20; t++) begin
      make_stream($urandom_range(6, 0), ($urandom_range(3, 0) != 0), s);
      run_load(s, $urandom_range(3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The processor core only ever reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake, carrying a length header, the program words and a checksum.
- Assembles little-endian 32-bit words, writes them to sequential word addresses, checks an XOR checksum, then releases the core from hold.
- Sits between a host byte source (e.g. UART receiver) and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk_in  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start_in  input  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERROR only
- byte_in  input  8  stream data byte
- byte_valid_in  input  1  byte_in is valid
- byte_ready_out  output  1  loader can accept a byte; a transfer occurs when valid and ready are both high at an edge
- imem_write_en_out  output  1  instruction memory write strobe, one cycle per word
- imem_addr_out  output  ADDR_WIDTH  word address of the write
- imem_data_out  output  32  assembled word
- core_hold_out  output  1  holds the core in reset while high
- done_out  output  1  load completed and checksum passed
- error_out  output  1  load aborted (oversize length or checksum mismatch)
- words_loaded_out  output  16  count of words written in the current load

Behaviour:
- Reset: state IDLE. byte_ready_out, imem_write_en_out, done_out and error_out are 0. imem_addr_out, imem_data_out, words_loaded_out, the checksum register and the byte counter are 0. core_hold_out is 1.
- States are IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- byte_ready_out is 1 exactly in LEN_LO, LEN_HI, DATA and CHECK. It is registered from state, so a transfer is never lost.
- Arbitrary gaps in byte_valid_in are tolerated; the state holds with no side effects.

State transitions:
- IDLE/DONE/ERROR + start_in -> LEN_LO. Same edge: clear done_out, error_out, words_loaded_out and the checksum; set core_hold_out=1.
- start_in is ignored in every other state.
- LEN_LO: the transferred byte becomes length[7:0] -> LEN_HI.
- LEN_HI: the transferred byte becomes length[15:8].
  - If length > 2^ADDR_WIDTH -> ERROR.
  - Else if length == 0 -> CHECK.
  - Else -> DATA.
- DATA: bytes are packed little-endian; the first byte goes to bits [7:0]. A 2-bit byte counter tracks position.
  - Every payload byte is XORed into an 8-bit checksum.
  - On transfer of the 4th byte: at the next edge imem_write_en_out=1 for exactly one cycle, imem_addr_out = current word index, imem_data_out = assembled word. The word index and words_loaded_out increment on that same edge.
  - After the 4th byte of word length-1 -> CHECK.
  - byte_ready_out stays high during the write cycle; back-to-back bytes are accepted at full rate.
- CHECK: the transferred byte is compared with the checksum. Equal -> DONE; unequal -> ERROR.
- DONE: done_out=1, core_hold_out=0.
- ERROR: error_out=1, core_hold_out=1. Words already written remain in memory.

Boundary conditions:
- length == 2^ADDR_WIDTH is legal. The word address wraps back to 0 only after the final write and is never used.
- Header bytes are excluded from the checksum.
- Reset mid-load: return to IDLE at that edge. A pending write strobe is dropped, and no write occurs in the cycle after reset.
- Reset and start_in asserted together: reset wins.
- done_out and error_out are never high together.

Test Plan:
- Nominal load, 2 words. Stream 02 00 13 00 00 00 93 00 10 00 90 -> writes addr0=0x00000013 and addr1=0x00100093, one strobe each; done_out=1, core_hold_out=0, words_loaded_out=2.
- Zero-length load. Stream 00 00 00 -> no writes, done_out=1.
- Checksum mismatch. Same stream as the nominal load with last byte 91 -> both writes occur, then error_out=1, core_hold_out=1, done_out=0.
- Oversize length. Stream 01 04 with ADDR_WIDTH=10 -> ERROR right after LEN_HI, byte_ready_out=0, no writes.
- Valid gaps and random idle cycles across the nominal stream -> identical writes and result; each write strobe exactly one cycle wide.
- Reset after 6 payload bytes, then start_in and a full nominal stream -> exactly 2 writes (0x00000013 at addr0 written only once post-restart), done_out=1.
- Restart from DONE. Pulse start_in -> done_out=0 and core_hold_out=1 on the same edge; a second load then overwrites from addr0.
